// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester-side handshake bundle for the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    // Requester drives the access, arbiter answers with grant and read return
    modport master (output req, we, addr, din, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, din, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter/sequencer for a single-port registered-read RAM
module ram_port_arbiter #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     a,
    ram_port_arbiter_if.slave     b,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout,
    output logic                  busy
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state;
    logic   last_b;     // 1 = B won the most recent grant
    logic   a_gnt_q;
    logic   b_gnt_q;
    logic   a_rvalid_q;
    logic   b_rvalid_q;
    logic   pick_a;

    // A wins when it is alone, or on a tie when fixed priority or B won last time
    assign pick_a = a.req && (!b.req || (PRIO_MODE == 1) || last_b);

    // Read data is the RAM output passed straight through; rvalid qualifies it
    assign a.gnt    = a_gnt_q;
    assign b.gnt    = b_gnt_q;
    assign a.rvalid = a_rvalid_q;
    assign b.rvalid = b_rvalid_q;
    assign a.rdata  = ram_dout;
    assign b.rdata  = ram_dout;

    // Two-state sequencer: IDLE arbitrates and registers the access, ACCESS lets the RAM run it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            busy       <= 1'b0;
        end else begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (a.req || b.req) begin
                        ram_en   <= 1'b1;
                        ram_we   <= pick_a ? a.we   : b.we;
                        ram_addr <= pick_a ? a.addr : b.addr;
                        ram_din  <= pick_a ? a.din  : b.din;
                        a_gnt_q  <= pick_a;
                        b_gnt_q  <= !pick_a;
                        last_b   <= !pick_a;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end else begin
                        ram_en  <= 1'b0;
                        ram_we  <= 1'b0;
                        a_gnt_q <= 1'b0;
                        b_gnt_q <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ACCESS: begin
                    // The winner's REQ is still high here; it is deliberately ignored
                    a_rvalid_q <= a_gnt_q && !ram_we;
                    b_rvalid_q <= b_gnt_q && !ram_we;
                    ram_en     <= 1'b0;
                    ram_we     <= 1'b0;
                    a_gnt_q    <= 1'b0;
                    b_gnt_q    <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench running round-robin and fixed-priority arbiters side by side
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus for both arbiters
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_din, b_addr, b_din;

    ram_port_arbiter_if #(.DW(8), .AW(8)) rr_a ();
    ram_port_arbiter_if #(.DW(8), .AW(8)) rr_b ();
    ram_port_arbiter_if #(.DW(8), .AW(8)) fp_a ();
    ram_port_arbiter_if #(.DW(8), .AW(8)) fp_b ();

    assign rr_a.req = a_req; assign rr_a.we = a_we; assign rr_a.addr = a_addr; assign rr_a.din = a_din;
    assign rr_b.req = b_req; assign rr_b.we = b_we; assign rr_b.addr = b_addr; assign rr_b.din = b_din;
    assign fp_a.req = a_req; assign fp_a.we = a_we; assign fp_a.addr = a_addr; assign fp_a.din = a_din;
    assign fp_b.req = b_req; assign fp_b.we = b_we; assign fp_b.addr = b_addr; assign fp_b.din = b_din;

    logic       rr_en, rr_we, rr_busy, fp_en, fp_we, fp_busy;
    logic [7:0] rr_addr, rr_din, rr_dout, fp_addr, fp_din, fp_dout;

    ram_port_arbiter #(.DW(8), .AW(8), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .a(rr_a), .b(rr_b),
        .ram_en(rr_en), .ram_we(rr_we), .ram_addr(rr_addr), .ram_din(rr_din),
        .ram_dout(rr_dout), .busy(rr_busy)
    );

    ram_port_arbiter #(.DW(8), .AW(8), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .a(fp_a), .b(fp_b),
        .ram_en(fp_en), .ram_we(fp_we), .ram_addr(fp_addr), .ram_din(fp_din),
        .ram_dout(fp_dout), .busy(fp_busy)
    );

    // Behavioural 256x8 RAMs with registered read data
    logic [7:0] mem_rr [256];
    logic [7:0] mem_fp [256];
    always @(posedge clk) begin
        if (rr_en) begin
            if (rr_we) mem_rr[rr_addr] <= rr_din;
            else       rr_dout <= mem_rr[rr_addr];
        end
        if (fp_en) begin
            if (fp_we) mem_fp[fp_addr] <= fp_din;
            else       fp_dout <= mem_fp[fp_addr];
        end
    end

    // Scoreboard: kind 0 = A grant, 1 = B grant, 2 = A rvalid, 3 = B rvalid
    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic push(input int d, input int c, input int kind, input logic [7:0] data);
        exp_t e;
        e.cyc = c; e.kind = kind; e.data = data;
        if (d == 0) q_rr.push_back(e);
        else        q_fp.push_back(e);
    endtask

    task automatic push_both(input int c, input int kind, input logic [7:0] data);
        push(0, c, kind, data);
        push(1, c, kind, data);
    endtask

    task automatic observe(input int d, input int kind, input logic [7:0] data);
        exp_t e;
        bit   have;
        n_cmp++;
        have = (d == 0) ? (q_rr.size() > 0) : (q_fp.size() > 0);
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got kind=%0d cyc=%0d data=%02h, required no event", d, kind, cyc, data);
            return;
        end
        if (d == 0) e = q_rr.pop_front();
        else        e = q_fp.pop_front();
        if (e.cyc != cyc || e.kind != kind || (kind >= 2 && e.data !== data)) begin
            n_fail++;
            $display("FAIL event dut%0d: got kind=%0d cyc=%0d data=%02h, required kind=%0d cyc=%0d data=%02h",
                     d, kind, cyc, data, e.kind, e.cyc, e.data);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic monitor_dut(input int d, input logic ga, input logic gb, input logic va, input logic vb,
                               input logic [7:0] da, input logic [7:0] db, input logic en, input logic bz);
        if (ga) observe(d, 0, 8'h00);
        if (gb) observe(d, 1, 8'h00);
        if (va) observe(d, 2, da);
        if (vb) observe(d, 3, db);
        check($sformatf("dut%0d_en_vs_gnt", d), {31'b0, en}, {31'b0, ga | gb});
        check($sformatf("dut%0d_busy_vs_en", d), {31'b0, bz}, {31'b0, en});
    endtask

    // Monitor samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        monitor_dut(0, rr_a.gnt, rr_b.gnt, rr_a.rvalid, rr_b.rvalid, rr_a.rdata, rr_b.rdata, rr_en, rr_busy);
        monitor_dut(1, fp_a.gnt, fp_b.gnt, fp_a.rvalid, fp_b.rvalid, fp_a.rdata, fp_b.rdata, fp_en, fp_busy);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rr_en"},    {31'b0, rr_en},       0);
        check({tag, "_rr_busy"},  {31'b0, rr_busy},     0);
        check({tag, "_rr_agnt"},  {31'b0, rr_a.gnt},    0);
        check({tag, "_rr_arv"},   {31'b0, rr_a.rvalid}, 0);
        check({tag, "_fp_en"},    {31'b0, fp_en},       0);
        check({tag, "_fp_busy"},  {31'b0, fp_busy},     0);
        check({tag, "_fp_agnt"},  {31'b0, fp_a.gnt},    0);
        check({tag, "_fp_arv"},   {31'b0, fp_a.rvalid}, 0);
    endtask

    // One uncontended access from A (who_b=0) or B (who_b=1); same answer in both modes
    task automatic single(input bit who_b, input logic we, input logic [7:0] addr, input logic [7:0] din,
                          input logic [7:0] exp_rd);
        int n;
        n = cyc;
        if (who_b) begin b_req = 1; b_we = we; b_addr = addr; b_din = din; end
        else       begin a_req = 1; a_we = we; a_addr = addr; a_din = din; end
        push_both(n + 1, who_b ? 1 : 0, 8'h00);
        if (!we) push_both(n + 2, who_b ? 3 : 2, exp_rd);
        step();
        step();
        a_req = 0;
        b_req = 0;
    endtask

    // Both requesters write; A holds REQ for a_len cycles, B for b_len cycles
    task automatic contend(input int a_len, input int b_len,
                           input logic [7:0] aa, input logic [7:0] ad,
                           input logic [7:0] ba, input logic [7:0] bd);
        int last;
        last = (a_len > b_len) ? a_len : b_len;
        a_req = 1; a_we = 1; a_addr = aa; a_din = ad;
        b_req = 1; b_we = 1; b_addr = ba; b_din = bd;
        for (int k = 1; k <= last; k++) begin
            step();
            if (k == a_len) a_req = 0;
            if (k == b_len) b_req = 0;
        end
    endtask

    initial begin
        int n;
        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_din = 0;
        repeat (3) step();

        check("reset_rr_addr", {24'b0, rr_addr}, 0);
        check("reset_rr_din",  {24'b0, rr_din},  0);
        check("reset_rr_we",   {31'b0, rr_we},   0);
        check("reset_rr_bgnt", {31'b0, rr_b.gnt}, 0);
        check("reset_fp_addr", {24'b0, fp_addr}, 0);
        check("reset_fp_bgnt", {31'b0, fp_b.gnt}, 0);
        check_idle_outputs("reset");
        rst_n = 1;
        step();

        // A write 0x5A to 0x10 then read it back
        single(0, 1, 8'h10, 8'h5A, 8'h00);
        single(0, 0, 8'h10, 8'h00, 8'h5A);

        // B writes 0xC3 to 0xFF, A reads it
        single(1, 1, 8'hFF, 8'hC3, 8'h00);
        single(0, 0, 8'hFF, 8'h00, 8'hC3);

        // Reset in the ACCESS cycle of an A read: no grant seen at the sample point, no rvalid ever
        a_req = 1; a_we = 0; a_addr = 8'h10;
        step();
        rst_n = 0;
        #1;
        check_idle_outputs("midreset");
        a_req = 0;
        step();
        step();
        rst_n = 1;
        #1;
        check_idle_outputs("postreset");
        step();

        // Both hold REQ 8 cycles from reset: RR A,B,A,B; FP A,A,A,A
        n = cyc;
        push(0, n + 1, 0, 8'h00); push(0, n + 3, 1, 8'h00);
        push(0, n + 5, 0, 8'h00); push(0, n + 7, 1, 8'h00);
        push(1, n + 1, 0, 8'h00); push(1, n + 3, 0, 8'h00);
        push(1, n + 5, 0, 8'h00); push(1, n + 7, 0, 8'h00);
        contend(8, 8, 8'h20, 8'h11, 8'h21, 8'h22);

        // A drops after 4 cycles, B holds 6: RR A,B,B; FP A,A,B
        n = cyc;
        push(0, n + 1, 0, 8'h00); push(0, n + 3, 1, 8'h00); push(0, n + 5, 1, 8'h00);
        push(1, n + 1, 0, 8'h00); push(1, n + 3, 0, 8'h00); push(1, n + 5, 1, 8'h00);
        contend(4, 6, 8'h30, 8'h33, 8'h31, 8'h44);

        // Read back what the contention phases wrote
        single(0, 0, 8'h31, 8'h00, 8'h44);
        single(1, 0, 8'h20, 8'h00, 8'h11);
        single(1, 0, 8'h10, 8'h00, 8'h5A);

        repeat (4) step();

        n_cmp++;
        if (q_rr.size() != 0 || q_fp.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d rr / %0d fp outstanding, required 0 / 0", q_rr.size(), q_fp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
